// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants for the UART transmit path.
//            Holds the issue FSM state encoding and the byte width.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : Circular byte FIFO with registered level/full/empty.
//            Overflow flag and counter exist only with UART_TX_BUF_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_dat,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_dat,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    level
`ifdef UART_TX_BUF_OVF_EN
    ,
    output logic                   ovf,
    output logic [7:0]             ovf_cnt
`endif
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   c_lvl_one = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   c_depth   = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_full;
    logic                   r_empty;

    logic                   w_push;
    logic                   w_pop;
    logic [DEPTH_LOG2:0]    w_level_nxt;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push = wr_en && !r_full;
    assign w_pop  = rd_en && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_lvl_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_depth);
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign rd_dat = r_mem[r_rd_ptr];
    assign full   = r_full;
    assign empty  = r_empty;
    assign level  = r_level;

`ifdef UART_TX_BUF_OVF_EN
    logic       r_ovf;
    logic [7:0] r_ovf_cnt;
    logic       w_drop;

    assign w_drop = wr_en && r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_ovf_cnt <= 8'h00;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'h01;
            end
        end
    end

    assign ovf     = r_ovf;
    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Purpose  : Transmit byte FIFO plus issue FSM feeding the UART transceiver.
//            Optional overflow reporting is enabled by UART_TX_BUF_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_dat,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    level,
    output logic [UART_BYTE_W-1:0] tx_dat,
    output logic                   tx_wr_ev,
    input  logic                   tx_ready,
    input  logic                   tx_done_ev
`ifdef UART_TX_BUF_OVF_EN
    ,
    output logic                   ovf,
    output logic [7:0]             ovf_cnt
`endif
);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [UART_BYTE_W-1:0] r_tx_dat;
    logic                   r_tx_wr_ev;
    logic [UART_BYTE_W-1:0] w_head;
    logic                   w_issue;
    logic                   w_pop;

    uart_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_dat  (wr_dat),
        .rd_en   (w_pop),
        .rd_dat  (w_head),
        .full    (full),
        .empty   (empty),
        .level   (level)
`ifdef UART_TX_BUF_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt)
`endif
    );

    assign w_issue = (r_state == IDLE) && !empty && tx_ready;
    // The head is captured on the entry edge and popped during the ISSUE cycle.
    assign w_pop   = (r_state == ISSUE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_issue)    w_state_nxt = ISSUE;
            ISSUE:                     w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done_ev) w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_dat   <= '0;
            r_tx_wr_ev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_wr_ev <= w_issue;
            if (w_issue) begin
                r_tx_dat <= w_head;
            end
        end
    end

    assign tx_dat   = r_tx_dat;
    assign tx_wr_ev = r_tx_wr_ev;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Purpose  : Self-checking bench for uart_tx_buffer (DEPTH_LOG2 = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [7:0]     wr_dat = 8'h00;
    logic           full;
    logic           empty;
    logic [DL2:0]   level;
    logic [7:0]     tx_dat;
    logic           tx_wr_ev;
    logic           tx_ready = 1'b0;
    logic           tx_done_ev = 1'b0;
`ifdef UART_TX_BUF_OVF_EN
    logic           ovf;
    logic [7:0]     ovf_cnt;
`endif

    uart_tx_buffer #(
        .DEPTH_LOG2 (DL2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_dat     (wr_dat),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .tx_dat     (tx_dat),
        .tx_wr_ev   (tx_wr_ev),
        .tx_ready   (tx_ready),
        .tx_done_ev (tx_done_ev)
`ifdef UART_TX_BUF_OVF_EN
        ,
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue, transmitter phase (0 idle, 1 strobe, 2 busy)
    logic [7:0] mq[$];
    int         m_phase = 0;
    logic [7:0] m_dat = 8'h00;
    logic       m_ovf = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    logic [7:0] got_dat[$];
    int         got_cyc[$];
    int         done_cyc[$];
    logic [7:0] push_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] dat;
        logic       rdy;
        logic       done;
        logic [2:0] lvl;
        logic       ev;
        logic [7:0] txd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model from this cycle's inputs, then compare.
    task automatic tick();
        int         sz;
        logic [7:0] head;
        logic       push_ok;
        sz      = mq.size();
        head    = (sz > 0) ? mq[0] : 8'h00;
        push_ok = wr_en && (sz < DEPTH);
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_dat   = 8'h00;
            m_ovf   = 1'b0;
            m_cnt   = 8'h00;
        end else begin
            if (wr_en && !push_ok) begin
                m_ovf = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            end
            case (m_phase)
                0: if (sz > 0 && tx_ready) begin
                    m_phase = 1;
                    m_dat   = head;
                end
                1: begin
                    head    = mq.pop_front();
                    m_phase = 2;
                end
                default: if (tx_done_ev) m_phase = 0;
            endcase
            if (push_ok) mq.push_back(wr_dat);
        end
        @(posedge sys_clk);
        #1;
        chk("model_level", level, mq.size());
        chk("model_empty", empty, mq.size() == 0);
        chk("model_full", full, mq.size() == DEPTH);
        chk("model_wr_ev", tx_wr_ev, m_phase == 1);
        chk("model_tx_dat", tx_dat, m_dat);
`ifdef UART_TX_BUF_OVF_EN
        chk("model_ovf", ovf, m_ovf);
        chk("model_ovf_cnt", ovf_cnt, m_cnt);
`endif
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        wr_en      = 1'b0;
        tx_done_ev = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Acts as the transceiver: records strobes and returns done 'delay' cycles later.
    task automatic watch(input int ncyc, input int delay);
        int done_at;
        done_at = -1;
        got_dat.delete();
        got_cyc.delete();
        done_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (tx_wr_ev) begin
                got_dat.push_back(tx_dat);
                got_cyc.push_back(c);
                done_at = c + delay;
            end
            tx_done_ev = (c == done_at);
            if (tx_done_ev) done_cyc.push_back(c);
            if (push_q.size() > 0) begin
                wr_en  = 1'b1;
                wr_dat = push_q.pop_front();
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        tx_done_ev = 1'b0;
        wr_en      = 1'b0;
    endtask

    initial begin
        int strobes;

        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA5};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA5};
        vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'hA5};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h3C};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h3C};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h3C};

        // Reset state, single byte, spurious done, tx_ready gating
        do_reset();
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].lvl == 3'd0);
            chk($sformatf("vec%0d_wr_ev", i), tx_wr_ev, vecs[i].ev);
            chk($sformatf("vec%0d_tx_dat", i), tx_dat, vecs[i].txd);
            wr_en      = vecs[i].wr;
            wr_dat     = vecs[i].dat;
            tx_ready   = vecs[i].rdy;
            tx_done_ev = vecs[i].done;
            tick();
        end
        wr_en      = 1'b0;
        tx_done_ev = 1'b0;

        // Ordering with done returned 100 cycles after each strobe
        do_reset();
        tx_ready = 1'b1;
        push_q   = '{8'h01, 8'h02, 8'h03};
        watch(400, 100);
        chk("order_count", got_dat.size(), 3);
        if (got_dat.size() == 3 && done_cyc.size() >= 2) begin
            chk("order_b0", got_dat[0], 8'h01);
            chk("order_b1", got_dat[1], 8'h02);
            chk("order_b2", got_dat[2], 8'h03);
            chk("order_first_latency", got_cyc[0], 2);
            chk("order_gap1", got_cyc[1] - done_cyc[0], 2);
            chk("order_gap2", got_cyc[2] - done_cyc[1], 2);
        end

        // Full and overflow
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en  = 1'b1;
            wr_dat = 8'h10 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("full_level", level, 4);
        chk("full_full", full, 1'b1);
        chk("full_empty", empty, 1'b0);
`ifdef UART_TX_BUF_OVF_EN
        chk("full_ovf", ovf, 1'b1);
        chk("full_ovf_cnt", ovf_cnt, 8'd2);
`endif
        tx_ready = 1'b1;
        watch(60, 5);
        chk("full_tx_count", got_dat.size(), 4);
        for (int i = 0; i < got_dat.size() && i < 4; i++) begin
            chk($sformatf("full_tx_b%0d", i), got_dat[i], 8'h10 + 8'(i));
        end

        // Push during the ISSUE cycle with level 3
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en  = 1'b1;
            wr_dat = 8'h20 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("sim_level_before", level, 3);
        tx_ready = 1'b1;
        tick();
        chk("sim_issue_ev", tx_wr_ev, 1'b1);
        chk("sim_issue_dat", tx_dat, 8'h20);
        wr_en  = 1'b1;
        wr_dat = 8'h23;
        tick();
        wr_en = 1'b0;
        chk("sim_level_after", level, 3);
        chk("sim_full_after", full, 1'b0);

        // Reset during WAIT_DONE with two bytes queued
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en  = 1'b1;
            wr_dat = 8'h30 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("rmf_level_queued", level, 2);
        chk("rmf_tx_dat", tx_dat, 8'h30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmf_level", level, 0);
        chk("rmf_tx_dat_clr", tx_dat, 8'h00);
        chk("rmf_empty", empty, 1'b1);
        tx_done_ev = 1'b1;
        tick();
        tx_done_ev = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_wr_ev) strobes++;
            tick();
        end
        chk("rmf_no_strobe", strobes, 0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            wr_en      = ($urandom_range(99) < 45);
            wr_dat     = 8'($urandom());
            tx_ready   = ($urandom_range(99) < 70);
            tx_done_ev = (m_phase == 2) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
            rst        = ($urandom_range(599) == 0);
            tick();
        end
        rst        = 1'b0;
        wr_en      = 1'b0;
        tx_done_ev = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and issue controller on the transmit side of the UART, directly upstream of the transceiver's `tx_dat`/`tx_wr_ev` inputs. A host or stimulus block pushes bytes at any rate up to one per clock. The buffer hands the bytes to the transceiver one at a time: it pulses `tx_wr_ev` only when the transceiver reports `tx_ready`, then holds off until `tx_done_ev` closes that frame. Bytes leave in strict write order.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4. FIFO depth is 2^DEPTH_LOG2 entries; legal range is 1–8.

Ports:
- `sys_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push request; sampled on rising `sys_clk`.
- `wr_dat`  in  8  byte to push.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `level`  out  DEPTH_LOG2+1  current occupancy.
- `tx_dat`  out  8  byte presented to the transceiver.
- `tx_wr_ev`  out  1  one-cycle load strobe to the transceiver.
- `tx_ready`  in  1  transceiver idle and able to accept a byte.
- `tx_done_ev`  in  1  one-cycle pulse from the transceiver at the end of a frame.
- `ovf`  out  1  sticky overflow flag. Present only with `UART_TX_BUF_OVF_EN`.
- `ovf_cnt`  out  8  count of dropped writes. Present only with `UART_TX_BUF_OVF_EN`.

## Operation
- Storage: circular buffer with write and read pointers of DEPTH_LOG2 bits each. Pointers wrap modulo the depth. `level` is an explicit counter.
- Push: when `wr_en` is high and `full` is low, `wr_dat` is stored and `level` increments.
- Push while `full`: the byte is dropped and no state changes. This holds even if a pop happens in the same cycle.
- Pop and push in the same cycle (not full): `level` is unchanged and both pointers advance.
- Issue FSM, three states:
  - IDLE: moves to ISSUE when `!empty && tx_ready`.
  - ISSUE: lasts exactly one cycle. `tx_wr_ev`=1, `tx_dat` = head byte (registered on the entry edge), and the head is popped. Next state is WAIT_DONE.
  - WAIT_DONE: stays until `tx_done_ev`=1, then goes to IDLE.
- `tx_done_ev` in IDLE or ISSUE is ignored. This covers stale pulses left over after a reset.
- `tx_dat` holds the last issued byte until the next ISSUE.
- Reset values: both pointers 0, `level` 0, `empty` 1, `full` 0, `tx_dat` 8'h00, `tx_wr_ev` 0, FSM in IDLE. With the macro defined, `ovf` 0 and `ovf_cnt` 0.
- Reset during WAIT_DONE: buffered bytes are discarded and the FSM returns to IDLE. A frame already in the transceiver finishes on its own; its `tx_done_ev` is ignored.

## Timing
- `full`, `empty` and `level` are registered and reflect a push or pop on the cycle after the clock edge that sampled it.
- Latency from push into an empty FIFO to the load strobe, with `tx_ready` high:
  - `wr_en` high in cycle 0.
  - `empty`=0 in cycle 1, FSM leaves IDLE at the end of cycle 1.
  - `tx_wr_ev`=1 in cycle 2.
- Back-to-back frames: the earliest next ISSUE is 2 cycles after the `tx_done_ev` cycle. The FSM passes through IDLE, which rechecks `tx_ready`.
- `tx_wr_ev` is never high on two consecutive cycles. It is never asserted while the FSM is in WAIT_DONE.

## Configuration
- Macro: `UART_TX_BUF_OVF_EN`.
- Defined:
  - `ovf` sets on any push attempted while `full` and stays set until `rst`.
  - `ovf_cnt` increments on each dropped write and saturates at 8'hFF.
- Undefined: both ports and their logic are absent, and dropped writes are silent. All other behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2;
  - `UART_BYTE_W`=8.
- Sub-module `uart_byte_fifo`: storage, pointers, `level`, `full`/`empty`, and overflow detection. The top level holds the issue FSM and the `tx_dat` register.

## Test plan
- Single byte: reset, push 8'hA5 in cycle 0 with `tx_ready`=1 → `tx_wr_ev` high in cycle 2 only, `tx_dat`=8'hA5, `empty`=1 from cycle 3.
- Ordering: push 8'h01, 8'h02, 8'h03 back-to-back, and the model returns `tx_done_ev` 100 cycles after each strobe → exactly three strobes, in order 01/02/03, each strobe 2 cycles after the previous `tx_done_ev`.
- Full and overflow: with DEPTH_LOG2=2 and `tx_ready`=0, push 6 bytes → `level`=4, `full`=1, and only the first 4 bytes are later transmitted. With the macro defined, `ovf`=1 and `ovf_cnt`=2.
- Simultaneous push/pop: with `level`=3, push in the ISSUE cycle → `level` stays 3 and `full` stays 0.
- Spurious done: pulse `tx_done_ev` while IDLE and empty → no `tx_wr_ev` and no state change.
- Reset mid-frame: assert `rst` during WAIT_DONE with 2 bytes queued, then deliver `tx_done_ev` → `level`=0, `tx_dat`=8'h00, and no further `tx_wr_ev`.
